// File: rtl/alu_if.sv
// Operand/result bundle for the single-cycle ALU.
// The master drives the op and operands; the slave returns the registered result.
interface alu_if #(
  parameter int W = 16
);
  logic [2:0]   ALUOp;
  logic [W-1:0] R2;
  logic [W-1:0] R3;
  logic [W-1:0] R1;
  logic         c_out;

  modport master (
    output ALUOp, R2, R3,
    input  R1, c_out
  );

  modport slave (
    input  ALUOp, R2, R3,
    output R1, c_out
  );
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU: the result of ALUOp(R2,R3) lands in R1/c_out
// one clock after the operands are presented; synchronous active-low reset.
module alu #(
  parameter int W = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_XOR  = 3'd5,
    OP_SLT  = 3'd6,
    OP_NOR  = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic         c;
    logic [W-1:0] r;
  } alu_rsp_t;

  alu_op_e      op;
  logic [W-1:0] a, b;
  logic [W:0]   sum, dif;
  logic         lt;
  alu_rsp_t     rsp_d, rsp_q;

  assign op = alu_op_e'(bus.ALUOp);
  assign a  = bus.R2;
  assign b  = bus.R3;

  // Both arithmetic paths are W+1 wide so the top bit is the carry (or not-borrow).
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign lt  = $signed(a) < $signed(b);

  always_comb begin
    rsp_d = '0;
    unique case (op)
      OP_PASS: rsp_d.r = a;
      OP_AND:  rsp_d.r = a & b;
      OP_OR:   rsp_d.r = a | b;
      OP_ADD:  rsp_d   = sum;
      OP_SUB:  rsp_d   = dif;
      OP_XOR:  rsp_d.r = a ^ b;
      OP_SLT:  rsp_d.r = {{(W-1){1'b0}}, lt};
      OP_NOR:  rsp_d.r = ~(a | b);
      default: rsp_d   = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rsp_q <= '0;
    else        rsp_q <= rsp_d;
  end

  assign bus.R1    = rsp_q.r;
  assign bus.c_out = rsp_q.c;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected {c_out,R1} is queued when operands are
// driven and popped one edge later when the registered result appears.
module tb_alu;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [W:0] sb[$];

  alu_if #(.W(W)) bus ();

  alu #(.W(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built on plain integer arithmetic.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    int unsigned s;
    shortint     sa, sb2;
    case (op)
      3'd0: return {1'b0, a};
      3'd1: return {1'b0, a & b};
      3'd2: return {1'b0, a | b};
      3'd3: begin s = 32'(a) + 32'(b); return s[W:0]; end
      3'd4: begin s = 32'(a) + 32'(16'(~b)) + 32'd1; return s[W:0]; end
      3'd5: return {1'b0, a ^ b};
      3'd6: begin
        sa = a; sb2 = b;
        return (sa < sb2) ? 17'd1 : 17'd0;
      end
      default: return {1'b0, ~(a | b)};
    endcase
  endfunction

  // Drive operands and queue the result the next edge should register.
  task automatic apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ALUOp = op;
    bus.R2    = a;
    bus.R3    = b;
    if (!rst_n) sb.push_back('0);
    else        sb.push_back(model(op, a, b));
  endtask

  task automatic test_reset;
    logic [W:0] exp;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply(3'd3, 16'h1234, 16'h5678);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({bus.c_out, bus.R1} !== exp || exp !== 17'h0) begin
        $display("FAIL reset_hold[%0d] got %h want %h", i, {bus.c_out, bus.R1}, 17'h0);
        errors++;
      end
    end
    rst_n = 1'b1;
    apply(3'd3, 16'h1234, 16'h5678);
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++;
    if ({bus.c_out, bus.R1} !== exp || exp !== 17'h068AC) begin
      $display("FAIL reset_release got %h want %h", {bus.c_out, bus.R1}, 17'h068AC);
      errors++;
    end
  endtask

  task automatic test_comb_hold;
    logic [W:0] held;
    held = {bus.c_out, bus.R1};
    bus.ALUOp = 3'd7; bus.R2 = 16'h0000; bus.R3 = 16'h0000;
    #2;
    checks++;
    if ({bus.c_out, bus.R1} !== 17'h068AC) begin
      $display("FAIL comb_hold got %h want %h (was %h)", {bus.c_out, bus.R1}, 17'h068AC, held);
      errors++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub;
    logic [W:0] exp;
    logic [W:0] want[3] = '{17'h10000, 17'h0FFFF, 17'h10000};
    apply(3'd3, 16'hFFFF, 16'h0001); @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp = sb.pop_front();
      checks++;
      if ({bus.c_out, bus.R1} !== exp || exp !== want[i]) begin
        $display("FAIL add_sub[%0d] got %h want %h", i, {bus.c_out, bus.R1}, want[i]);
        errors++;
      end
      if (i == 0) begin apply(3'd4, 16'h0001, 16'h0002); @(posedge clk); #1; end
      if (i == 1) begin apply(3'd4, 16'h0005, 16'h0005); @(posedge clk); #1; end
    end
  endtask

  task automatic test_pass_track;
    logic [W:0] exp;
    for (int i = 0; i < 20; i++) begin
      apply(3'd0, 16'(i / 5), 16'hA5A5);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({bus.c_out, bus.R1} !== exp || bus.c_out !== 1'b0) begin
        $display("FAIL pass[%0d] got %h want %h", i, {bus.c_out, bus.R1}, exp);
        errors++;
      end
    end
  endtask

  task automatic test_slt;
    logic [W:0] exp;
    logic [W-1:0] a[4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0003};
    logic [W-1:0] b[4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0003};
    logic [W:0]   w[4] = '{17'd1, 17'd0, 17'd1, 17'd0};
    for (int i = 0; i < 4; i++) begin
      apply(3'd6, a[i], b[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({bus.c_out, bus.R1} !== exp || exp !== w[i]) begin
        $display("FAIL slt[%0d] got %h want %h", i, {bus.c_out, bus.R1}, w[i]);
        errors++;
      end
    end
  endtask

  task automatic test_logic;
    logic [W:0] exp;
    logic [2:0] ops[4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    logic [W:0] w[4]   = '{17'h0F000, 17'h0FFF0, 17'h00FF0, 17'h0000F};
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], 16'hF0F0, 16'hFF00);
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({bus.c_out, bus.R1} !== exp || exp !== w[i]) begin
        $display("FAIL logic_op%0d got %h want %h", ops[i], {bus.c_out, bus.R1}, w[i]);
        errors++;
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [W:0] exp;
    apply(3'd3, 16'hFFFF, 16'hFFFF);
    void'(sb.pop_back());
    rst_n = 1'b0;
    sb.push_back('0);
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++;
    if ({bus.c_out, bus.R1} !== exp) begin
      $display("FAIL mid_reset got %h want %h", {bus.c_out, bus.R1}, exp);
      errors++;
    end
    rst_n = 1'b1;
    apply(3'd4, 16'h0010, 16'h0001);
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++;
    if ({bus.c_out, bus.R1} !== exp || exp !== 17'h1000F) begin
      $display("FAIL after_mid_reset got %h want %h", {bus.c_out, bus.R1}, 17'h1000F);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    logic [W:0] exp;
    for (int i = 0; i < 60; i++) begin
      apply(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({bus.c_out, bus.R1} !== exp) begin
        $display("FAIL b2b[%0d] op=%0d got %h want %h", i, bus.ALUOp, {bus.c_out, bus.R1}, exp);
        errors++;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.ALUOp = 3'd0; bus.R2 = '0; bus.R3 = '0;
    #1;
    test_reset;
    test_comb_hold;
    test_add_sub;
    test_pass_track;
    test_slt;
    test_logic;
    test_mid_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
